mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and `wb_stage`. Accepts one instruction per handshake from EX, waits for the SRAM-like data-bus response of any load/store that EX issued, aligns and extends load data, and presents the final result plus CSR/exception fields on `ms_to_ws_bus`. Provides forwarding and stall information to decode, and discards responses that belong to instructions killed by WB exception/ertn flushes.

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_load_align.sv | 35 +++
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load opcodes and state encoding for the memory-access stage.
// Also holds the saturating counter helper used for in-flight response discards.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 172;
    localparam int MS_TO_WS_BUS_WD = 168;
    localparam int MS_FORWARD_WD   = 72;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_B    = 3'b001;
    localparam logic [2:0] LD_H    = 3'b010;
    localparam logic [2:0] LD_W    = 3'b011;
    localparam logic [2:0] LD_BU   = 3'b100;
    localparam logic [2:0] LD_HU   = 3'b101;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_READY = 2'd2
    } ms_state_e;

    function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[2] ? 2'd3 : s[1:0];
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load response and sign/zero-extends it.
// Unknown opcodes (including 110/111) fall through to the full word.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_ld_op)
            LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
            LD_H:    o_result = {{16{w_half[15]}}, w_half};
            LD_BU:   o_result = {24'd0, w_byte};
            LD_HU:   o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its data-bus response,
// aligns load data and drops responses owed to instructions killed by a WB flush.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    output logic                       ms_to_ws_valid,
    input  logic                       ws_allowin,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       excp_flush,
    input  logic                       ertn_flush
);

    ms_state_e    r_state;
    ms_state_e    w_state_nxt;
    logic [166:0] r_bus;
    logic [2:0]   r_ld_op;
    logic         r_ertn;
    logic [31:0]  r_rdata;
    logic [1:0]   r_discard_cnt;
    logic [1:0]   w_discard_nxt;
    logic [1:0]   w_cnt_after_ok;
    logic [1:0]   w_flush_inc;

    logic        w_ms_valid;
    logic        w_ready_go;
    logic        w_flush;
    logic        w_accept;
    logic        w_drop;
    logic        w_data_hit;
    logic        w_not_ready;
    logic [31:0] w_load_result;
    logic [31:0] w_final_result;

    assign w_ms_valid     = (r_state != MS_EMPTY);
    assign w_ready_go     = (r_state == MS_READY);
    assign w_flush        = excp_flush | ertn_flush;
    assign ms_allowin     = !w_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = w_ms_valid & w_ready_go;
    assign w_accept       = es_to_ms_valid & ms_allowin & !w_flush;

    // A response goes to the oldest owner: killed instructions first, then the one in WAIT.
    assign w_drop     = data_sram_data_ok & (r_discard_cnt != 2'd0);
    assign w_data_hit = data_sram_data_ok & (r_discard_cnt == 2'd0) & (r_state == MS_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        if (w_flush)
            w_state_nxt = MS_EMPTY;
        else if (w_accept)
            w_state_nxt = (es_to_ms_bus[167] & !es_to_ms_bus[71]) ? MS_WAIT : MS_READY;
        else if (w_ready_go & ws_allowin)
            w_state_nxt = MS_EMPTY;
        else if (w_data_hit)
            w_state_nxt = MS_READY;
    end

    // A WAIT request answered in the flush cycle itself no longer needs discarding.
    always_comb begin
        w_cnt_after_ok = r_discard_cnt - {1'b0, w_drop};
        w_flush_inc    = {1'b0, (r_state == MS_WAIT) & !w_data_hit}
                       + {1'b0, es_to_ms_valid & es_to_ms_bus[167]};
        w_discard_nxt  = w_flush ? sat_add2(w_cnt_after_ok, w_flush_inc) : w_cnt_after_ok;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= MS_EMPTY;
            r_discard_cnt <= 2'd0;
            r_bus         <= '0;
            r_ld_op       <= LD_NONE;
            r_ertn        <= 1'b0;
            r_rdata       <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_discard_cnt <= w_discard_nxt;
            if (w_accept) begin
                r_bus   <= es_to_ms_bus[166:0];
                r_ld_op <= es_to_ms_bus[170:168];
                r_ertn  <= es_to_ms_bus[171];
            end
            if (w_data_hit)
                r_rdata <= data_sram_rdata;
        end
    end

    load_align u_load_align (
        .i_ld_op  (r_ld_op),
        .i_offset (r_bus[33:32]),
        .i_rdata  (r_rdata),
        .o_result (w_load_result)
    );

    assign w_final_result = (r_ld_op != LD_NONE) ? w_load_result : r_bus[63:32];
    assign w_not_ready    = w_ms_valid & ((r_state == MS_WAIT) | r_bus[70]);

    assign ms_to_ws_bus = {r_ertn, r_bus[166:64], w_final_result, r_bus[31:0]};
    assign ms_forward   = {w_not_ready, r_bus[31:0], w_final_result,
                           r_bus[68:64], r_bus[69], w_ms_valid};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment, late responses,
// flush-induced response discards and WB back-pressure.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         es_to_ms_valid;
    logic [171:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ms_to_ws_valid;
    logic         ws_allowin;
    logic [167:0] ms_to_ws_bus;
    logic [71:0]  ms_forward;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         excp_flush;
    logic         ertn_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush)
    );

    function automatic logic [171:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                            input logic [4:0] dest, input logic mem_req,
                                            input logic excp, input logic [2:0] ld_op,
                                            input logic ertn);
        logic [171:0] b;
        b = '0;
        b[31:0]    = pc;
        b[63:32]   = alu;
        b[68:64]   = dest;
        b[69]      = 1'b1;
        b[71]      = excp;
        b[167]     = mem_req;
        b[170:168] = ld_op;
        b[171]     = ertn;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one load, answer it after lat WAIT cycles, then check the aligned result.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rd, input int lat, input logic [31:0] exp);
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(32'h1c00_0100, addr, 5'd9, 1'b1, 1'b0, op, 1'b0);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            #1;
            chk({tag, "_wait_allowin"}, 64'(ms_allowin), 64'd0);
            chk({tag, "_wait_fwd_nr"}, 64'(ms_forward[71]), 64'd1);
            chk({tag, "_wait_valid"}, 64'(ms_to_ws_valid), 64'd0);
            @(negedge clk);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk({tag, "_valid"}, 64'(ms_to_ws_valid), 64'd1);
        chk({tag, "_result"}, 64'(ms_to_ws_bus[63:32]), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        excp_flush        = 1'b0;
        ertn_flush        = 1'b0;
        #2;
        chk("rst_valid", 64'(ms_to_ws_valid), 64'd0);
        chk("rst_allowin", 64'(ms_allowin), 64'd1);
        chk("rst_fwd_valid", 64'(ms_forward[0]), 64'd0);
        chk("rst_bus", 64'(ms_to_ws_bus[63:0]), 64'd0);
        chk("rst_discard", 64'(dut.r_discard_cnt), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // ALU op passes straight through in one cycle
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(32'h1c00_0000, 32'h5, 5'd7, 1'b0, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        chk("alu_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("alu_result", 64'(ms_to_ws_bus[63:32]), 64'h5);
        chk("alu_pc", 64'(ms_to_ws_bus[31:0]), 64'h1c00_0000);
        chk("alu_ertn", 64'(ms_to_ws_bus[167]), 64'd1);
        chk("alu_fwd", 64'(ms_forward[38:0]), 64'({32'h5, 5'd7, 1'b1, 1'b1}));
        chk("alu_fwd_nr", 64'(ms_forward[71]), 64'd0);
        @(negedge clk);
        #1;
        chk("alu_drain", 64'(ms_to_ws_valid), 64'd0);

        // Load alignment
        do_load("ldb", 3'b001, 32'h0000_1003, 32'h80FF_0000, 0, 32'hFFFF_FF80);
        do_load("ldbu", 3'b100, 32'h0000_1003, 32'h80FF_0000, 0, 32'h0000_0080);
        do_load("ldhu", 3'b101, 32'h0000_1002, 32'h80FF_0000, 0, 32'h0000_80FF);
        do_load("ldw_late", 3'b011, 32'h0000_2000, 32'hCAFE_F00D, 3, 32'hCAFE_F00D);
        do_load("ld_op7", 3'b111, 32'h0000_2001, 32'h1234_5678, 1, 32'h1234_5678);

        // Excepting op with mem_req set goes straight to READY
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(32'h1c00_0200, 32'h77, 5'd3, 1'b1, 1'b1, 3'b000, 1'b0);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        chk("excp_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("excp_result", 64'(ms_to_ws_bus[63:32]), 64'h77);

        // Flush while a load is in WAIT: its response must be dropped
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(32'h1c00_0300, 32'h3000, 5'd4, 1'b1, 1'b0, 3'b011, 1'b0);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        excp_flush     = 1'b1;
        @(negedge clk);
        excp_flush = 1'b0;
        #1;
        chk("fl1_cnt", 64'(dut.r_discard_cnt), 64'd1);
        chk("fl1_valid", 64'(ms_to_ws_valid), 64'd0);
        chk("fl1_allowin", 64'(ms_allowin), 64'd1);
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(32'h1c00_0304, 32'h3004, 5'd5, 1'b1, 1'b0, 3'b011, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("fl1_cnt_zero", 64'(dut.r_discard_cnt), 64'd0);
        chk("fl1_still_wait", 64'(ms_to_ws_valid), 64'd0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("fl1_new_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("fl1_new_result", 64'(ms_to_ws_bus[63:32]), 64'h1234_5678);

        // Flush with MS in WAIT and EX presenting an issued load: two drops
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(32'h1c00_0400, 32'h4000, 5'd6, 1'b1, 1'b0, 3'b011, 1'b0);
        @(negedge clk);
        es_to_ms_bus = mk_bus(32'h1c00_0404, 32'h4004, 5'd6, 1'b1, 1'b0, 3'b011, 1'b0);
        ertn_flush   = 1'b1;
        @(negedge clk);
        ertn_flush = 1'b0;
        #1;
        chk("fl2_cnt2", 64'(dut.r_discard_cnt), 64'd2);
        es_to_ms_bus      = mk_bus(32'h1c00_0408, 32'h4008, 5'd6, 1'b1, 1'b0, 3'b011, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_1111;
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0000_2222;
        #1;
        chk("fl2_cnt1", 64'(dut.r_discard_cnt), 64'd1);
        chk("fl2_wait1", 64'(ms_to_ws_valid), 64'd0);
        @(negedge clk);
        data_sram_rdata = 32'h3333_4444;
        #1;
        chk("fl2_cnt0", 64'(dut.r_discard_cnt), 64'd0);
        chk("fl2_wait2", 64'(ms_to_ws_valid), 64'd0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("fl2_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("fl2_result", 64'(ms_to_ws_bus[63:32]), 64'h3333_4444);

        // WB back-pressure holds a READY load and blocks EX
        @(negedge clk);
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(32'h1c00_0500, 32'h5002, 5'd8, 1'b1, 1'b0, 3'b010, 1'b0);
        @(negedge clk);
        es_to_ms_bus      = mk_bus(32'h1c00_0504, 32'h99, 5'd8, 1'b0, 1'b0, 3'b000, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        #1;
        chk("bp_wait_allowin", 64'(ms_allowin), 64'd0);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        chk("bp_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("bp_result", 64'(ms_to_ws_bus[63:32]), 64'hFFFF_8001);
        chk("bp_allowin", 64'(ms_allowin), 64'd0);
        @(negedge clk);
        #1;
        chk("bp_hold_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("bp_hold_result", 64'(ms_to_ws_bus[63:32]), 64'hFFFF_8001);
        chk("bp_hold_pc", 64'(ms_to_ws_bus[31:0]), 64'h1c00_0500);
        chk("bp_hold_allowin", 64'(ms_allowin), 64'd0);
        ws_allowin = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        chk("bp_next_valid", 64'(ms_to_ws_valid), 64'd1);
        chk("bp_next_result", 64'(ms_to_ws_bus[63:32]), 64'h99);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
